// File: rtl/cla_pkg.sv
// Shared sizing helpers and the default stage-register layout for the
// pipelined carry-lookahead adder/subtractor.
package cla_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_GROUP = 4;

    function automatic int calc_ng(input int w, input int g);
        return (g > 0) ? (w / g) : 0;
    endfunction

    function automatic bit width_ok(input int w, input int g);
        return (g > 0) && (w >= g) && ((w % g) == 0);
    endfunction

    localparam int DEF_NG = calc_ng(DEF_WIDTH, DEF_GROUP);

    // One pipeline stage at the default width: sum bits resolved so far,
    // group carry-out, operands still to be consumed, and MSB carry-in.
    typedef struct packed {
        logic                 valid;
        logic [DEF_WIDTH-1:0] sum;
        logic                 cout;
        logic [DEF_WIDTH-1:0] x;
        logic [DEF_WIDTH-1:0] y;
        logic                 cmsb;
    } stage_t;

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice: every carry is formed
// directly from generate/propagate terms and the group carry-in.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] i_x,
    input  logic [GROUP-1:0] i_y,
    input  logic             i_cin,
    output logic [GROUP-1:0] o_sum,
    output logic             o_cout,
    output logic             o_cmsb
);

    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_p;
    logic [GROUP:0]   w_c;
    logic             w_term;
    logic             w_acc;

    assign w_g = i_x & i_y;
    assign w_p = i_x ^ i_y;

    // c[i] = cin&p[0..i-1]  |  OR over j<i of g[j]&p[j+1..i-1]
    always_comb begin
        w_c    = '0;
        w_term = 1'b0;
        w_acc  = 1'b0;
        for (int i = 0; i <= GROUP; i++) begin
            w_acc = i_cin;
            for (int j = 0; j < i; j++) begin
                w_acc = w_acc & w_p[j];
            end
            for (int j = 0; j < i; j++) begin
                w_term = w_g[j];
                for (int m = j + 1; m < i; m++) begin
                    w_term = w_term & w_p[m];
                end
                w_acc = w_acc | w_term;
            end
            w_c[i] = w_acc;
        end
    end

    assign o_sum  = w_p ^ w_c[GROUP-1:0];
    assign o_cout = w_c[GROUP];
    assign o_cmsb = w_c[GROUP-1];

endmodule

// File: rtl/cla_pipe.sv
// Pipelined adder/subtractor: one lookahead group resolved per stage, all
// stages advance together under a single enable driven by the output side.
module cla_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GROUP = DEF_GROUP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NG = calc_ng(WIDTH, GROUP);

    if (!width_ok(WIDTH, GROUP)) begin : g_bad_width
        $error("cla_pipe: WIDTH must be a non-zero multiple of GROUP");
    end

    // Handshake: a beat moves on a rising edge when valid && ready. The
    // whole pipe advances when the output slot is empty or being taken.
    logic w_en;
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    // Bubbles enter as zeros so idle stages carry a clean zero result.
    logic [WIDTH-1:0] w_x0;
    logic [WIDTH-1:0] w_y0;
    logic             w_c0;
    assign w_x0 = in_valid ? in_x : '0;
    assign w_y0 = in_valid ? (in_sub ? ~in_y : in_y) : '0;
    assign w_c0 = in_valid & (in_sub | in_cin);

    logic             r_valid [NG];
    logic [WIDTH-1:0] r_sum   [NG];
    logic             r_cout  [NG];
    logic [WIDTH-1:0] r_x     [NG];
    logic [WIDTH-1:0] r_y     [NG];
    logic             r_ovf;

    logic             w_v_src    [NG];
    logic [WIDTH-1:0] w_x_src    [NG];
    logic [WIDTH-1:0] w_y_src    [NG];
    logic             w_c_src    [NG];
    logic [WIDTH-1:0] w_sum_prev [NG];
    logic [WIDTH-1:0] w_sum_nxt  [NG];
    logic [GROUP-1:0] w_gsum     [NG];
    logic             w_gcout    [NG];
    logic             w_gcmsb    [NG];
    logic [NG-1:0]    w_unused_bits;
    logic             w_unused;

    for (genvar k = 0; k < NG; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_v_src[k]    = in_valid;
            assign w_x_src[k]    = w_x0;
            assign w_y_src[k]    = w_y0;
            assign w_c_src[k]    = w_c0;
            assign w_sum_prev[k] = '0;
        end else begin : g_next
            assign w_v_src[k]    = r_valid[k-1];
            assign w_x_src[k]    = r_x[k-1];
            assign w_y_src[k]    = r_y[k-1];
            assign w_c_src[k]    = r_cout[k-1];
            assign w_sum_prev[k] = r_sum[k-1];
        end

        cla_group #(.GROUP(GROUP)) u_group (
            .i_x    (w_x_src[k][k*GROUP +: GROUP]),
            .i_y    (w_y_src[k][k*GROUP +: GROUP]),
            .i_cin  (w_c_src[k]),
            .o_sum  (w_gsum[k]),
            .o_cout (w_gcout[k]),
            .o_cmsb (w_gcmsb[k])
        );

        assign w_sum_nxt[k]     = w_sum_prev[k] | (WIDTH'(w_gsum[k]) << (k*GROUP));
        assign w_unused_bits[k] = ^{r_x[k], r_y[k], w_gcmsb[k]};
    end

    assign w_unused = ^w_unused_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NG; k++) begin
                r_valid[k] <= 1'b0;
                r_sum[k]   <= '0;
                r_cout[k]  <= 1'b0;
                r_x[k]     <= '0;
                r_y[k]     <= '0;
            end
            r_ovf <= 1'b0;
        end else if (w_en) begin
            for (int k = 0; k < NG; k++) begin
                r_valid[k] <= w_v_src[k];
                r_sum[k]   <= w_sum_nxt[k];
                r_cout[k]  <= w_gcout[k];
                r_x[k]     <= w_x_src[k];
                r_y[k]     <= w_y_src[k];
            end
            r_ovf <= w_gcmsb[NG-1] ^ w_gcout[NG-1];
        end
    end

    assign out_valid = r_valid[NG-1];
    assign out_sum   = r_sum[NG-1];
    assign out_cout  = r_cout[NG-1];
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_cla_pipe.sv
// Self-checking bench for cla_pipe: directed corner cases, a stalled random
// stream, reset flush, and three alternate WIDTH/GROUP builds.
module tb_cla_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // main 16/4 instance
    logic        m_in_valid = 1'b0;
    logic        m_in_ready;
    logic [15:0] m_in_x = '0;
    logic [15:0] m_in_y = '0;
    logic        m_in_cin = 1'b0;
    logic        m_in_sub = 1'b0;
    logic        m_out_valid;
    logic        m_out_ready = 1'b1;
    logic [15:0] m_out_sum;
    logic        m_out_cout;
    logic        m_out_ovf;

    cla_pipe #(.WIDTH(16), .GROUP(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in_x(m_in_x), .in_y(m_in_y), .in_cin(m_in_cin), .in_sub(m_in_sub),
        .out_valid(m_out_valid), .out_ready(m_out_ready),
        .out_sum(m_out_sum), .out_cout(m_out_cout), .out_ovf(m_out_ovf)
    );

    // alternate builds share one stimulus stream, output always ready
    logic        s_valid = 1'b0;
    logic [31:0] s_x = '0;
    logic [31:0] s_y = '0;
    logic        s_cin = 1'b0;
    logic        s_sub = 1'b0;
    logic        a8_ready, a8_valid, a8_cout, a8_ovf;
    logic [7:0]  a8_sum;
    logic        a32_ready, a32_valid, a32_cout, a32_ovf;
    logic [31:0] a32_sum;
    logic        a12_ready, a12_valid, a12_cout, a12_ovf;
    logic [11:0] a12_sum;

    cla_pipe #(.WIDTH(8), .GROUP(2)) u_a8 (
        .clk(clk), .rst(rst),
        .in_valid(s_valid), .in_ready(a8_ready),
        .in_x(s_x[7:0]), .in_y(s_y[7:0]), .in_cin(s_cin), .in_sub(s_sub),
        .out_valid(a8_valid), .out_ready(1'b1),
        .out_sum(a8_sum), .out_cout(a8_cout), .out_ovf(a8_ovf)
    );

    cla_pipe #(.WIDTH(32), .GROUP(8)) u_a32 (
        .clk(clk), .rst(rst),
        .in_valid(s_valid), .in_ready(a32_ready),
        .in_x(s_x), .in_y(s_y), .in_cin(s_cin), .in_sub(s_sub),
        .out_valid(a32_valid), .out_ready(1'b1),
        .out_sum(a32_sum), .out_cout(a32_cout), .out_ovf(a32_ovf)
    );

    cla_pipe #(.WIDTH(12), .GROUP(12)) u_a12 (
        .clk(clk), .rst(rst),
        .in_valid(s_valid), .in_ready(a12_ready),
        .in_x(s_x[11:0]), .in_y(s_y[11:0]), .in_cin(s_cin), .in_sub(s_sub),
        .out_valid(a12_valid), .out_ready(1'b1),
        .out_sum(a12_sum), .out_cout(a12_cout), .out_ovf(a12_ovf)
    );

    localparam int N_ALT = 1000;
    logic        hv   [N_ALT];
    logic [31:0] hx   [N_ALT];
    logic [31:0] hy   [N_ALT];
    logic        hsub [N_ALT];
    logic        hcin [N_ALT];

    logic [17:0] exp_q [$];

    // Reference: plain modular arithmetic; ovf from operand/result signs.
    function automatic logic [65:0] ref_model(input int w, input logic [63:0] x,
                                              input logic [63:0] y, input logic sub,
                                              input logic cin);
        logic [63:0] mask, xx, yy, full;
        logic        c0, co, ov;
        mask = (64'd1 << w) - 64'd1;
        xx   = x & mask;
        yy   = sub ? (~y & mask) : (y & mask);
        c0   = sub ? 1'b1 : cin;
        full = xx + yy + {63'd0, c0};
        co   = full[w];
        ov   = (xx[w-1] == yy[w-1]) && (full[w-1] != xx[w-1]);
        return {ov, co, full & mask};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic sub, input logic cin, input logic [15:0] es,
                            input logic ec, input logic eo);
        int lat;
        m_in_valid  = 1'b1;
        m_in_x      = x;
        m_in_y      = y;
        m_in_sub    = sub;
        m_in_cin    = cin;
        m_out_ready = 1'b1;
        #1;
        chk({tag, " ready"}, m_in_ready, 1);
        step();
        m_in_valid = 1'b0;
        lat = 1;
        #1;
        while (!m_out_valid && lat < 20) begin
            step();
            lat++;
            #1;
        end
        chk({tag, " latency"}, lat, 4);
        chk({tag, " sum"}, m_out_sum, es);
        chk({tag, " cout"}, m_out_cout, ec);
        chk({tag, " ovf"}, m_out_ovf, eo);
        step();
    endtask

    task automatic chk_alt(input string tag, input int w, input int ng, input int t,
                           input logic v, input logic [31:0] sum, input logic co,
                           input logic ov);
        logic        ev;
        logic [65:0] r;
        ev = (t >= ng) ? hv[t-ng] : 1'b0;
        chk({tag, " valid"}, v, ev);
        if (ev) begin
            r = ref_model(w, {32'd0, hx[t-ng]}, {32'd0, hy[t-ng]}, hsub[t-ng], hcin[t-ng]);
            chk({tag, " sum"}, {32'd0, sum}, r[63:0]);
            chk({tag, " cout"}, co, r[64]);
            chk({tag, " ovf"}, ov, r[65]);
        end
    endtask

    initial begin
        int          sent, recv, cyc;
        logic        acc, stall_prev;
        logic [17:0] held, e;
        logic [65:0] r;

        // reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("reset out_valid", m_out_valid, 0);
        chk("reset out_sum", m_out_sum, 0);
        chk("reset out_cout", m_out_cout, 0);
        chk("reset out_ovf", m_out_ovf, 0);
        chk("reset in_ready", m_in_ready, 1);
        step();

        // directed corners
        directed("add ffff+1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("add 7fff+1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("add cin", 16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2346, 1'b0, 1'b0);
        directed("sub 5-7", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        directed("sub 8000-1", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // random stream with random output back-pressure
        sent = 0;
        recv = 0;
        cyc = 0;
        stall_prev = 1'b0;
        held = '0;
        m_in_valid = 1'b0;
        while (recv < 64 && cyc < 3000) begin
            if (sent < 64 && !m_in_valid) begin
                m_in_valid = 1'b1;
                m_in_x     = 16'($urandom);
                m_in_y     = 16'($urandom);
                m_in_sub   = 1'($urandom_range(0, 1));
                m_in_cin   = 1'($urandom_range(0, 1));
            end
            m_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("stream in_ready", m_in_ready, !(m_out_valid && !m_out_ready));
            if (stall_prev)
                chk("stream hold", {m_out_valid, m_out_ovf, m_out_cout, m_out_sum}, {1'b1, held});
            stall_prev = m_out_valid && !m_out_ready;
            held = {m_out_ovf, m_out_cout, m_out_sum};
            if (m_out_valid && m_out_ready) begin
                chk("stream expected beat", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("stream result", {m_out_ovf, m_out_cout, m_out_sum}, e);
                end
                recv++;
            end
            acc = m_in_valid && m_in_ready;
            if (acc) begin
                r = ref_model(16, {48'd0, m_in_x}, {48'd0, m_in_y}, m_in_sub, m_in_cin);
                exp_q.push_back({r[65:64], r[15:0]});
                sent++;
            end
            step();
            cyc++;
            if (acc) m_in_valid = 1'b0;
        end
        chk("stream beats delivered", recv, 64);
        chk("stream queue drained", exp_q.size(), 0);

        // flush: three beats in flight, then reset together with a new beat
        m_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_in_valid = 1'b1;
            m_in_x     = 16'($urandom);
            m_in_y     = 16'($urandom);
            m_in_sub   = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b1;
        m_in_x = 16'hFFFF;
        step();
        rst = 1'b0;
        m_in_valid = 1'b0;
        #1;
        chk("flush out_valid", m_out_valid, 0);
        chk("flush out_sum", m_out_sum, 0);
        chk("flush out_cout", m_out_cout, 0);
        chk("flush out_ovf", m_out_ovf, 0);
        chk("flush in_ready", m_in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("flush no output", m_out_valid, 0);
        end

        // alternate widths, full throughput, latency = WIDTH/GROUP
        for (int t = 0; t < N_ALT; t++) begin
            s_valid = ($urandom_range(0, 7) != 0);
            s_x     = $urandom;
            s_y     = $urandom;
            s_sub   = 1'($urandom_range(0, 1));
            s_cin   = 1'($urandom_range(0, 1));
            hv[t]   = s_valid;
            hx[t]   = s_x;
            hy[t]   = s_y;
            hsub[t] = s_sub;
            hcin[t] = s_cin;
            #1;
            chk_alt("w8g2", 8, 4, t, a8_valid, {24'd0, a8_sum}, a8_cout, a8_ovf);
            chk_alt("w32g8", 32, 4, t, a32_valid, a32_sum, a32_cout, a32_ovf);
            chk_alt("w12g12", 12, 1, t, a12_valid, {20'd0, a12_sum}, a12_cout, a12_ovf);
            step();
        end
        s_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
